// File: rtl/spi_slave_shift.sv
// SPI responder datapath in the PCLK domain.
// Oversamples SCLK/SS_n/MOSI, shifts MOSI in on the sample edge and MISO out on the shift edge,
// with a one-entry TX holding buffer and an RX holding register facing the register block.
//
// state | meaning
// IDLE  | deselected, MISO tristated, waiting for SS_n fall
// XFER  | selected, shifting bytes until SS_n rises
`timescale 1ns/1ps
module spi_slave_shift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       lsbfe_i,
    input  logic       sclk_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       underrun_o,
    output logic       overrun_o
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   ss_fall, ss_rise, lead_edge, trail_edge;
    logic                   cpol_q, cpha_q, lsbfe_q;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_shift, rx_shift, rx_next;
    logic [7:0]             buf_data, load_data;
    logic                   buf_full;
    logic                   frame_start, frame_end, sample_en, shift_en, byte_done, load;

    function automatic logic [7:0] shift_tx(input logic [7:0] d, input logic lsb);
        return lsb ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
    endfunction

    function automatic logic out_bit(input logic [7:0] d, input logic lsb);
        return lsb ? d[0] : d[7];
    endfunction

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign ss_s       = ss_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign ss_fall    = ss_d & ~ss_s;
    assign ss_rise    = ~ss_d & ss_s;
    // Edge polarity is relative to the latched idle level, so one detector serves all modes.
    assign lead_edge  = (sclk_s != cpol_q) && (sclk_d == cpol_q);
    assign trail_edge = (sclk_s == cpol_q) && (sclk_d != cpol_q);
    assign rx_next    = lsbfe_q ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};
    assign load_data  = buf_full ? buf_data : 8'h00;
    assign tx_ready_o = ~buf_full;

    // Synchronizers plus delay flops for edge detection; SCLK idles at cpol during reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sclk_sync <= {SYNC_STAGES{cpol_i}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= cpol_i;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        sample_en   = 1'b0;
        shift_en    = 1'b0;
        byte_done   = 1'b0;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = XFER;
                    frame_start = 1'b1;
                    load        = 1'b1;
                end
            end
            XFER: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end else begin
                    sample_en = cpha_q ? trail_edge : lead_edge;
                    shift_en  = cpha_q ? lead_edge : trail_edge;
                    byte_done = sample_en && (bit_cnt == 3'd7);
                    load      = byte_done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifters, config latch, MISO drive, RX holding register and status pulses.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbfe_q    <= 1'b0;
            bit_cnt    <= 3'd0;
            tx_shift   <= 8'h00;
            rx_shift   <= 8'h00;
            miso_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            rx_data_o  <= 8'h00;
            rx_valid_o <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            underrun_o <= load & ~buf_full;
            overrun_o  <= 1'b0;
            if (frame_start) begin
                cpol_q    <= cpol_i;
                cpha_q    <= cpha_i;
                lsbfe_q   <= lsbfe_i;
                bit_cnt   <= 3'd0;
                miso_oe_o <= 1'b1;
                // With cpha=0 the master samples on the first edge, so the first bit must already be out.
                if (!cpha_i) begin
                    miso_o   <= out_bit(load_data, lsbfe_i);
                    tx_shift <= shift_tx(load_data, lsbfe_i);
                end else begin
                    tx_shift <= load_data;
                end
            end else if (frame_end) begin
                miso_oe_o <= 1'b0;
                miso_o    <= 1'b0;
                bit_cnt   <= 3'd0;
                tx_shift  <= 8'h00;
                rx_shift  <= 8'h00;
            end else begin
                if (sample_en) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (shift_en) begin
                    miso_o   <= out_bit(tx_shift, lsbfe_q);
                    tx_shift <= shift_tx(tx_shift, lsbfe_q);
                end
                // Mid-frame reloads are presented by the following shift edge, never immediately.
                if (byte_done) tx_shift <= load_data;
            end
            if (byte_done) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
                overrun_o  <= rx_valid_o & ~rx_ack_i;
            end else if (rx_ack_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    // One-entry TX holding buffer; a write coinciding with a load lands here, not in the shifter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
        end else if (load && buf_full) begin
            buf_full <= 1'b0;
        end else if (tx_valid_i && !buf_full) begin
            buf_full <= 1'b1;
            buf_data <= tx_data_i;
        end
    end

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: a behavioural SPI master drives all four modes.
`timescale 1ns/1ps
module tb_spi_slave_shift;

    localparam int H = 8;   // SCLK half period in PCLK cycles

    logic       PCLK, PRESET;
    logic       cpol_i, cpha_i, lsbfe_i;
    logic       sclk_i, ss_n_i, mosi_i;
    logic       miso_o, miso_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ack_i;
    logic       underrun_o, overrun_o;

    int n_vec = 0;
    int n_err = 0;
    int und_cnt = 0;
    int ovr_cnt = 0;

    spi_slave_shift #(.SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
        .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i),
        .underrun_o(underrun_o), .overrun_o(overrun_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (underrun_o) und_cnt <= und_cnt + 1;
        if (overrun_o)  ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        cpol_i  = cpol;
        cpha_i  = cpha;
        lsbfe_i = lsb;
        sclk_i  = cpol;
        wait_cyc(6);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge PCLK);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge PCLK);
        tx_valid_i = 1'b0;
    endtask

    task automatic rx_ack();
        @(negedge PCLK);
        rx_ack_i = 1'b1;
        @(negedge PCLK);
        rx_ack_i = 1'b0;
    endtask

    task automatic frame_begin();
        ss_n_i = 1'b0;
        wait_cyc(H);
    endtask

    task automatic frame_end();
        wait_cyc(H);
        ss_n_i = 1'b1;
        wait_cyc(6);
    endtask

    // Master shifts nbits of tx, returns what it sampled from MISO.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbfe_i ? i : 7 - i;
            if (!cpha_i) begin
                mosi_i  = tx[idx];
                wait_cyc(H);
                sclk_i  = ~cpol_i;
                rx[idx] = miso_o;
                wait_cyc(H);
                sclk_i  = cpol_i;
            end else begin
                sclk_i  = ~cpol_i;
                mosi_i  = tx[idx];
                wait_cyc(H);
                sclk_i  = cpol_i;
                rx[idx] = miso_o;
                wait_cyc(H);
            end
        end
    endtask

    initial begin
        logic [7:0] g1, g2;
        int u0, o0;
        logic [2:0] m;

        PRESET = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0;
        sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
        tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ack_i = 1'b0;
        wait_cyc(4);
        PRESET = 1'b0;
        wait_cyc(1);
        check("rst_miso", miso_o, 0);
        check("rst_oe", miso_oe_o, 0);
        check("rst_rxdata", rx_data_o, 8'h00);
        check("rst_rxvalid", rx_valid_o, 0);
        check("rst_txready", tx_ready_o, 1);
        check("rst_underrun", underrun_o, 0);
        check("rst_overrun", overrun_o, 0);

        // Mode 0, MSB first.
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(8'hA5);
        check("m0_txready_full", tx_ready_o, 0);
        o0 = ovr_cnt;
        frame_begin();
        check("m0_oe", miso_oe_o, 1);
        spi_bits(8'h3C, 8, g1);
        frame_end();
        check("m0_miso", g1, 8'hA5);
        check("m0_rxdata", rx_data_o, 8'h3C);
        check("m0_rxvalid", rx_valid_o, 1);
        check("m0_overrun", ovr_cnt - o0, 0);
        check("m0_oe_off", miso_oe_o, 0);
        rx_ack();
        check("m0_ack", rx_valid_o, 0);

        // Modes 1..3, LSB first.
        for (int k = 1; k < 4; k++) begin
            m = 3'(k);
            set_mode(m[1], m[0], 1'b1);
            tx_write(8'h81);
            frame_begin();
            spi_bits(8'h7E, 8, g1);
            frame_end();
            check($sformatf("mode%0d_miso", k), g1, 8'h81);
            check($sformatf("mode%0d_rx", k), rx_data_o, 8'h7E);
            rx_ack();
        end

        // Two-byte frame, rx left unacked.
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(8'h11);
        o0 = ovr_cnt;
        frame_begin();
        tx_write(8'h22);
        spi_bits(8'hA1, 8, g1);
        spi_bits(8'hB2, 8, g2);
        frame_end();
        check("two_b1_miso", g1, 8'h11);
        check("two_b2_miso", g2, 8'h22);
        check("two_rxdata", rx_data_o, 8'hB2);
        check("two_rxvalid", rx_valid_o, 1);
        check("two_overrun", ovr_cnt - o0, 1);
        rx_ack();

        // Frame start with TX buffer empty.
        check("und_txready_pre", tx_ready_o, 1);
        u0 = und_cnt;
        frame_begin();
        check("und_pulse", und_cnt - u0, 1);
        spi_bits(8'h55, 8, g1);
        frame_end();
        check("und_miso", g1, 8'h00);
        check("und_txready", tx_ready_o, 1);
        check("und_rx", rx_data_o, 8'h55);

        // Abort after 5 bits; rx 0x55 still unread.
        frame_begin();
        spi_bits(8'hF0, 5, g1);
        frame_end();
        check("abort_oe", miso_oe_o, 0);
        check("abort_miso", miso_o, 0);
        check("abort_rxvalid", rx_valid_o, 1);
        check("abort_rxdata", rx_data_o, 8'h55);
        rx_ack();
        frame_begin();
        spi_bits(8'h0F, 8, g1);
        frame_end();
        check("after_abort_rx", rx_data_o, 8'h0F);
        check("after_abort_valid", rx_valid_o, 1);

        // Reset mid-byte, rx 0x0F still valid beforehand.
        tx_write(8'h5A);
        frame_begin();
        spi_bits(8'hC3, 4, g1);
        PRESET = 1'b1;
        wait_cyc(1);
        check("midrst_miso", miso_o, 0);
        check("midrst_oe", miso_oe_o, 0);
        check("midrst_rxdata", rx_data_o, 8'h00);
        check("midrst_rxvalid", rx_valid_o, 0);
        check("midrst_txready", tx_ready_o, 1);
        check("midrst_underrun", underrun_o, 0);
        check("midrst_overrun", overrun_o, 0);
        ss_n_i = 1'b1;
        sclk_i = cpol_i;
        wait_cyc(4);
        PRESET = 1'b0;
        wait_cyc(4);
        tx_write(8'h96);
        frame_begin();
        spi_bits(8'h69, 8, g1);
        frame_end();
        check("post_rst_miso", g1, 8'h96);
        check("post_rst_rx", rx_data_o, 8'h69);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
